add_sub_seq: RTL and testbench

//  Multi-cycle WIDTH-bit add/subtract unit for the integer datapath.
//  It time-shares one combinational 16-bit carry-lookahead adder slice over WIDTH/16 passes, LSB slice first.
//  A registered carry links each pass to the next.

---
 rtl/add_sub_seq.sv | 144 ++++++++++++++
 tb/tb_add_sub_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_seq.sv
// Multi-cycle WIDTH-bit add/subtract: one 16-bit carry-lookahead slice reused over WIDTH/16 passes,
// LSB slice first, with a registered carry between passes and valid/ready on both sides.

module add_sub_cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout,
    output logic        c_msb
);
    logic [15:0] g, p;
    logic [16:0] c;
    logic [3:0]  gg, gp;
    logic [4:0]  gc;

    assign g = a & b;
    assign p = a ^ b;

    // Two-level lookahead: 4-bit group generate/propagate, then bit carries inside each group.
    always_comb begin
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        gc[0] = cin;
        for (int k = 0; k < 4; k++)
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        for (int k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int j = 0; j < 3; j++)
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
        end
        c[16] = gc[4];
    end

    assign s     = p ^ c[15:0];
    assign cout  = c[16];
    assign c_msb = c[15];
endmodule

module add_sub_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z
);
    localparam int NPASS = WIDTH / 16;
    localparam int CW    = (NPASS > 1) ? $clog2(NPASS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q, bx_q;

    logic [15:0]      a_sl, b_sl, sum_sl;
    logic             sum_c, sum_cmsb;
    logic [WIDTH-1:0] s_next;
    logic             last;

    always_comb begin
        a_sl   = a_q[16*cnt +: 16];
        b_sl   = bx_q[16*cnt +: 16];
        s_next = out_s;
        s_next[16*cnt +: 16] = sum_sl;
    end

    assign last = (cnt == CW'(NPASS - 1));

    add_sub_cla16 u_slice (
        .a     (a_sl),
        .b     (b_sl),
        .cin   (carry),
        .s     (sum_sl),
        .cout  (sum_c),
        .c_msb (sum_cmsb)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            bx_q  <= '0;
            out_s <= '0;
            out_c <= 1'b0;
            out_v <= 1'b0;
            out_z <= 1'b0;
        end else if (flush) begin
            // Abort leaves the result register and flags as they were.
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q   <= in_a;
                    bx_q  <= in_b ^ {WIDTH{in_sub}};
                    carry <= in_sub;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    out_s <= s_next;
                    carry <= sum_c;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        // The final slice's top bit is the word MSB, so its carry-in feeds overflow.
                        out_c <= sum_c;
                        out_v <= sum_cmsb ^ sum_c;
                        out_z <= (s_next == '0);
                        cnt   <= '0;
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_sub_seq.sv
// Self-checking bench for add_sub_seq: directed vector table, abort/backpressure sequences,
// and a randomized back-to-back stream scored against an arithmetic reference model.

module tb_add_sub_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_s;
    logic         out_c, out_v, out_z;

    add_sub_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_c(out_c), .out_v(out_v), .out_z(out_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        res_t         exp;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk32(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: signed overflow from true signed arithmetic, carry from unsigned range/borrow.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        res_t   r;
        longint ua, ub, sa, sb, sr, smax, smin;
        ua   = longint'({32'b0, a});
        ub   = longint'({32'b0, b});
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        if (sub) begin
            r.s = W'(ua - ub);
            r.c = (ua >= ub);
            sr  = sa - sb;
        end else begin
            r.s = W'(ua + ub);
            r.c = ((ua + ub) >= (longint'(1) <<< W));
            sr  = sa + sb;
        end
        r.v = (sr > smax) || (sr < smin);
        r.z = (r.s == '0);
        return r;
    endfunction

    task automatic check_res(input string tag, input res_t e);
        chk32({tag, ".s"}, out_s, e.s);
        chk1({tag, ".c"}, out_c, e.c);
        chk1({tag, ".v"}, out_v, e.v);
        chk1({tag, ".z"}, out_z, e.z);
    endtask

    // Issue one op and wait (bounded) until out_valid; leaves out_ready low.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input string tag);
        int lat;
        @(negedge clk);
        chk1({tag, ".in_ready"}, in_ready, 1'b1);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chki({tag, ".latency"}, lat, 2);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input res_t e, input int hold, input string tag);
        launch(a, b, sub, tag);
        check_res(tag, e);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk1({tag, ".hold_valid"}, out_valid, 1'b1);
            chk1({tag, ".hold_in_ready"}, in_ready, 1'b0);
            chk32({tag, ".hold_s"}, out_s, e.s);
            chk1({tag, ".hold_c"}, out_c, e.c);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk1({tag, ".popped"}, out_valid, 1'b0);
        chk1({tag, ".ready_after"}, in_ready, 1'b1);
    endtask

    vec_t tv[6];

    initial begin
        res_t         e;
        logic [W-1:0] held;
        int           acc_cyc[$];
        res_t         expq[$];
        int           cyc, pops, accepts;
        bit           pending;

        tv[0] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, '{32'h0001_0000, 1'b0, 1'b0, 1'b0}};
        tv[1] = '{32'h1234_5678, 32'h1234_5678, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        tv[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        tv[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}};
        tv[4] = '{32'h0000_0000, 32'h0000_0001, 1'b1, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}};
        tv[5] = '{32'h0000_0002, 32'h0000_0003, 1'b0, '{32'h0000_0005, 1'b0, 1'b0, 1'b0}};

        // Reset state
        #12;
        chk1("rst.in_ready", in_ready, 1'b1);
        chk1("rst.out_valid", out_valid, 1'b0);
        chk32("rst.s", out_s, '0);
        chk1("rst.c", out_c, 1'b0);
        chk1("rst.v", out_v, 1'b0);
        chk1("rst.z", out_z, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) do_op(tv[i].a, tv[i].b, tv[i].sub, tv[i].exp, 0, $sformatf("vec%0d", i));

        // Unsigned wrap with 5 cycles of backpressure
        e = '{32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, e, 5, "wrap_bp");
        repeat (3) begin
            @(negedge clk);
            chk1("wrap_bp.single_xfer", out_valid, 1'b0);
        end

        // Flush while running: result never appears, unit ready next cycle
        @(negedge clk);
        in_a = 32'h1; in_b = 32'h1; in_sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk1("flush_run.in_ready", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("flush_run.no_valid", out_valid, 1'b0);
        end
        do_op(32'd2, 32'd3, 1'b0, model(32'd2, 32'd3, 1'b0), 0, "after_flush");

        // Flush together with in_valid in IDLE: operands refused
        @(negedge clk);
        in_a = 32'h10; in_b = 32'h20; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk1("flush_idle.in_ready", in_ready, 1'b1);
        repeat (3) @(negedge clk);
        chk1("flush_idle.no_valid", out_valid, 1'b0);

        // Flush with out_ready in DONE: flush wins, outputs untouched
        launch(32'h0000_1111, 32'h0000_2222, 1'b0, "flush_done");
        held = out_s;
        chk32("flush_done.s", held, 32'h0000_3333);
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        chk1("flush_done.valid", out_valid, 1'b0);
        chk1("flush_done.in_ready", in_ready, 1'b1);
        chk32("flush_done.s_held", out_s, held);

        // Asynchronous reset while result is held
        launch(32'd5, 32'd5, 1'b0, "rst_done");
        #2 rst_n = 1'b0;
        #1;
        chk1("rst_done.valid", out_valid, 1'b0);
        chk1("rst_done.in_ready", in_ready, 1'b1);
        chk32("rst_done.s", out_s, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back random stream with out_ready held high
        out_ready = 1'b1;
        cyc = 0; pops = 0; accepts = 0; pending = 1'b1;
        while (pops < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (pending) begin
                pending = 1'b0;
                if (accepts < 8) begin
                    in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom_range(0, 1));
                    in_valid = 1'b1;
                end else in_valid = 1'b0;
            end
            if (out_valid) begin
                if (expq.size() == 0) chki("stream.unexpected_result", 1, 0);
                else check_res($sformatf("stream%0d", pops), expq.pop_front());
                pops++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(in_a, in_b, in_sub));
                acc_cyc.push_back(cyc);
                accepts++;
                pending = 1'b1;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chki("stream.pops", pops, 8);
        for (int i = 1; i < acc_cyc.size(); i++)
            chki("stream.spacing", acc_cyc[i] - acc_cyc[i-1], 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
